// File: rtl/bus_arbiter_if.sv
// Bundle of the fetch port, data port and shared-bus signals around bus_arbiter.
// The master view belongs to the arbiter, which drives the shared bus.
// The slave view belongs to the cores and the bus on the other side.
interface bus_arbiter_if;
  logic        i_read_req;
  logic        i_read_w;
  logic        i_read_hw;
  logic [31:0] i_read_adr;
  logic        i_read_valid;
  logic [31:0] i_read_data;

  logic        d_req;
  logic        d_we;
  logic        d_w;
  logic        d_hw;
  logic [31:0] d_adr;
  logic [31:0] d_wdata;
  logic        d_valid;
  logic [31:0] d_rdata;

  logic        m_req;
  logic        m_we;
  logic        m_w;
  logic        m_hw;
  logic [31:0] m_adr;
  logic [31:0] m_wdata;
  logic        m_valid;
  logic [31:0] m_rdata;

  logic        bus_err;

  modport master (
    input  i_read_req, i_read_w, i_read_hw, i_read_adr,
    output i_read_valid, i_read_data,
    input  d_req, d_we, d_w, d_hw, d_adr, d_wdata,
    output d_valid, d_rdata,
    output m_req, m_we, m_w, m_hw, m_adr, m_wdata,
    input  m_valid, m_rdata,
    output bus_err
  );

  modport slave (
    output i_read_req, i_read_w, i_read_hw, i_read_adr,
    input  i_read_valid, i_read_data,
    output d_req, d_we, d_w, d_hw, d_adr, d_wdata,
    input  d_valid, d_rdata,
    input  m_req, m_we, m_w, m_hw, m_adr, m_wdata,
    output m_valid, m_rdata,
    input  bus_err
  );
endinterface

// File: rtl/bus_arbiter.sv
// Two-port round-robin arbiter: the instruction fetch port and the data port share
// one bus. Only one bus transaction is ever outstanding. A response that never
// arrives is closed by a timeout, which returns a NOP word and pulses bus_err.
//
// state  | meaning
// IDLE   | no transaction outstanding; issue m_req if a port is pending
// I_WAIT | fetch transaction outstanding, waiting for m_valid or timeout
// D_WAIT | data transaction outstanding, waiting for m_valid or timeout
module bus_arbiter #(
  parameter logic [7:0] TMO_CYC = 8'd255
) (
  input logic           clk,
  input logic           rst_n,
  bus_arbiter_if.master bus
);
  typedef enum logic [1:0] {IDLE = 2'd0, I_WAIT = 2'd1, D_WAIT = 2'd2} state_t;

  // Instruction word returned on a timeout (RISC-V NOP).
  localparam logic [31:0] TMO_DATA = 32'h0000_0013;

  state_t      state, state_nxt;
  logic        i_pend, d_pend;
  logic        last_d;
  logic [7:0]  tmo_cnt;

  logic        i_w_q, i_hw_q;
  logic [31:0] i_adr_q;
  logic        d_we_q, d_w_q, d_hw_q;
  logic [31:0] d_adr_q, d_wdata_q;

  logic        grant_i, grant_d, tmo_hit, wait_done, i_cap, d_cap;
  logic        m_req, m_we, m_w, m_hw;
  logic [31:0] m_adr, m_wdata, resp_data;
  logic        i_valid, d_valid, bus_err;
  logic [31:0] i_data, d_data;

  // A request is dropped while its port is pending or in flight. The one
  // exception is the completion cycle, so back-to-back requests are not lost.
  assign i_cap = bus.i_read_req && !i_pend && !(state == I_WAIT && !wait_done);
  assign d_cap = bus.d_req && !d_pend && !(state == D_WAIT && !wait_done);

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Grant selection, bus drive, response routing and timeout detection.
  always_comb begin
    state_nxt = state;
    grant_i   = 1'b0;
    grant_d   = 1'b0;
    tmo_hit   = 1'b0;
    wait_done = 1'b0;
    m_req     = 1'b0;
    m_we      = 1'b0;
    m_w       = 1'b0;
    m_hw      = 1'b0;
    m_adr     = '0;
    m_wdata   = '0;
    i_valid   = 1'b0;
    i_data    = '0;
    d_valid   = 1'b0;
    d_data    = '0;
    bus_err   = 1'b0;
    resp_data = bus.m_valid ? bus.m_rdata : TMO_DATA;
    case (state)
      IDLE: begin
        // Data wins a tie unless data was the last port granted.
        if (d_pend && (!i_pend || !last_d)) begin
          grant_d   = 1'b1;
          m_req     = 1'b1;
          m_we      = d_we_q;
          m_w       = d_w_q;
          m_hw      = d_hw_q;
          m_adr     = d_adr_q;
          m_wdata   = d_wdata_q;
          state_nxt = D_WAIT;
        end else if (i_pend) begin
          grant_i   = 1'b1;
          m_req     = 1'b1;
          m_w       = i_w_q;
          m_hw      = i_hw_q;
          m_adr     = i_adr_q;
          state_nxt = I_WAIT;
        end
      end
      I_WAIT, D_WAIT: begin
        // A real response in the last allowed cycle beats the timeout.
        tmo_hit   = !bus.m_valid && (tmo_cnt == TMO_CYC - 8'd1);
        wait_done = bus.m_valid || tmo_hit;
        bus_err   = tmo_hit;
        if (wait_done) begin
          state_nxt = IDLE;
          if (state == I_WAIT) begin
            i_valid = 1'b1;
            i_data  = resp_data;
          end else begin
            d_valid = 1'b1;
            d_data  = resp_data;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Pend flags, captured request fields, round-robin history and wait counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      i_pend    <= 1'b0;
      d_pend    <= 1'b0;
      last_d    <= 1'b0;
      tmo_cnt   <= '0;
      i_w_q     <= 1'b0;
      i_hw_q    <= 1'b0;
      i_adr_q   <= '0;
      d_we_q    <= 1'b0;
      d_w_q     <= 1'b0;
      d_hw_q    <= 1'b0;
      d_adr_q   <= '0;
      d_wdata_q <= '0;
    end else begin
      if (grant_i)    i_pend <= 1'b0;
      else if (i_cap) i_pend <= 1'b1;
      if (grant_d)    d_pend <= 1'b0;
      else if (d_cap) d_pend <= 1'b1;

      if (i_cap) begin
        i_w_q   <= bus.i_read_w;
        i_hw_q  <= bus.i_read_hw;
        i_adr_q <= bus.i_read_adr;
      end
      if (d_cap) begin
        d_we_q    <= bus.d_we;
        d_w_q     <= bus.d_w;
        d_hw_q    <= bus.d_hw;
        d_adr_q   <= bus.d_adr;
        d_wdata_q <= bus.d_wdata;
      end

      if (grant_i)      last_d <= 1'b0;
      else if (grant_d) last_d <= 1'b1;

      if (grant_i || grant_d)                 tmo_cnt <= '0;
      else if (state != IDLE && !bus.m_valid) tmo_cnt <= tmo_cnt + 8'd1;
    end
  end

  assign bus.m_req        = m_req;
  assign bus.m_we         = m_we;
  assign bus.m_w          = m_w;
  assign bus.m_hw         = m_hw;
  assign bus.m_adr        = m_adr;
  assign bus.m_wdata      = m_wdata;
  assign bus.i_read_valid = i_valid;
  assign bus.i_read_data  = i_data;
  assign bus.d_valid      = d_valid;
  assign bus.d_rdata      = d_data;
  assign bus.bus_err      = bus_err;
endmodule

// File: tb/tb_bus_arbiter.sv
// Testbench for bus_arbiter: a directed vector table, hand-written reset and
// timeout sequences, then random traffic checked against a transaction-level model.
module tb_bus_arbiter;
  localparam logic [7:0] TMO = 8'd4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  bus_arbiter_if bus();
  bus_arbiter #(.TMO_CYC(TMO)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic i_req; logic i_w; logic i_hw; logic [31:0] i_adr;
    logic d_req; logic d_we; logic d_w; logic d_hw; logic [31:0] d_adr; logic [31:0] d_wdata;
    logic m_valid; logic [31:0] m_rdata;
  } ins_t;

  typedef struct packed {
    logic m_req; logic m_we; logic m_w; logic m_hw; logic [31:0] m_adr; logic [31:0] m_wdata;
    logic i_valid; logic [31:0] i_data;
    logic d_valid; logic [31:0] d_rdata;
    logic bus_err;
  } outs_t;

  typedef struct {
    ins_t  in;
    outs_t exp;
    bit    dc;
  } vec_t;

  vec_t vecs[$];

  function automatic ins_t in_i(input logic [31:0] adr, input logic w, input logic hw);
    ins_t x = '0;
    x.i_req = 1'b1; x.i_adr = adr; x.i_w = w; x.i_hw = hw;
    return x;
  endfunction

  function automatic ins_t in_d(input logic we, input logic [31:0] adr, input logic [31:0] wd,
                                input logic w, input logic hw);
    ins_t x = '0;
    x.d_req = 1'b1; x.d_we = we; x.d_adr = adr; x.d_wdata = wd; x.d_w = w; x.d_hw = hw;
    return x;
  endfunction

  function automatic ins_t in_mv(input logic [31:0] rdata);
    ins_t x = '0;
    x.m_valid = 1'b1; x.m_rdata = rdata;
    return x;
  endfunction

  function automatic outs_t o_grant(input logic [31:0] adr, input logic we, input logic [31:0] wd,
                                    input logic w, input logic hw);
    outs_t e = '0;
    e.m_req = 1'b1; e.m_adr = adr; e.m_we = we; e.m_wdata = wd; e.m_w = w; e.m_hw = hw;
    return e;
  endfunction

  function automatic outs_t o_iv(input logic [31:0] data, input logic err);
    outs_t e = '0;
    e.i_valid = 1'b1; e.i_data = data; e.bus_err = err;
    return e;
  endfunction

  function automatic outs_t o_dv(input logic [31:0] data, input logic err);
    outs_t e = '0;
    e.d_valid = 1'b1; e.d_rdata = data; e.bus_err = err;
    return e;
  endfunction

  function automatic void add(input ins_t x, input outs_t e, input bit dc);
    vec_t v;
    v.in = x; v.exp = e; v.dc = dc;
    vecs.push_back(v);
  endfunction

  function automatic outs_t sample();
    outs_t a;
    a.m_req = bus.m_req; a.m_we = bus.m_we; a.m_w = bus.m_w; a.m_hw = bus.m_hw;
    a.m_adr = bus.m_adr; a.m_wdata = bus.m_wdata;
    a.i_valid = bus.i_read_valid; a.i_data = bus.i_read_data;
    a.d_valid = bus.d_valid; a.d_rdata = bus.d_rdata;
    a.bus_err = bus.bus_err;
    return a;
  endfunction

  task automatic apply(input ins_t x);
    bus.i_read_req = x.i_req; bus.i_read_w = x.i_w; bus.i_read_hw = x.i_hw; bus.i_read_adr = x.i_adr;
    bus.d_req = x.d_req; bus.d_we = x.d_we; bus.d_w = x.d_w; bus.d_hw = x.d_hw;
    bus.d_adr = x.d_adr; bus.d_wdata = x.d_wdata;
    bus.m_valid = x.m_valid; bus.m_rdata = x.m_rdata;
  endtask

  task automatic check(input string name, input outs_t e, input bit dc);
    outs_t a;
    a = sample();
    if (dc) begin
      a.d_rdata = '0;
      e.d_rdata = '0;
    end
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s t=%0t got %h want %h", name, $time, a, e);
    end
  endtask

  // Inputs are driven 1 time unit after the rising edge and outputs are sampled
  // on the falling edge.
  task automatic run_cycle(input ins_t x, input outs_t e, input bit dc, input string name);
    apply(x);
    @(negedge clk);
    check(name, e, dc);
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    apply('0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  // Transaction-level reference: port 0 = fetch, 1 = data; owner -1 = bus free.
  bit          pend[2];
  logic        cap_w[2], cap_hw[2];
  logic [31:0] cap_adr[2];
  logic        cap_we;
  logic [31:0] cap_wd;
  int          owner, grant_cyc, last, cyc;
  logic        fly_we;

  function automatic void model_reset();
    for (int p = 0; p < 2; p++) begin
      pend[p] = 1'b0; cap_w[p] = 1'b0; cap_hw[p] = 1'b0; cap_adr[p] = '0;
    end
    cap_we = 1'b0; cap_wd = '0; owner = -1; grant_cyc = 0; last = 0; cyc = 0; fly_we = 1'b0;
  endfunction

  function automatic void model_eval(input ins_t x, output outs_t e, output bit dc,
                                     output int grant, output bit done);
    logic [31:0] data;
    bit          tmo;
    e = '0; dc = 1'b0; grant = -1; done = 1'b0;
    if (owner < 0) begin
      if (pend[0] && pend[1]) grant = 1 - last;
      else if (pend[1])       grant = 1;
      else if (pend[0])       grant = 0;
      if (grant >= 0) begin
        e.m_req = 1'b1; e.m_adr = cap_adr[grant]; e.m_w = cap_w[grant]; e.m_hw = cap_hw[grant];
        if (grant == 1) begin
          e.m_we = cap_we; e.m_wdata = cap_wd;
        end
      end
    end else begin
      tmo  = !x.m_valid && ((cyc - grant_cyc) == int'(TMO));
      done = x.m_valid || tmo;
      if (done) begin
        data = x.m_valid ? x.m_rdata : 32'h0000_0013;
        if (owner == 0) begin
          e.i_valid = 1'b1; e.i_data = data;
        end else begin
          e.d_valid = 1'b1; e.d_rdata = data; dc = fly_we;
        end
        e.bus_err = tmo;
      end
    end
  endfunction

  function automatic void model_update(input ins_t x, input int grant, input bit done);
    if (x.i_req && !pend[0] && !(owner == 0 && !done)) begin
      pend[0] = 1'b1; cap_w[0] = x.i_w; cap_hw[0] = x.i_hw; cap_adr[0] = x.i_adr;
    end
    if (x.d_req && !pend[1] && !(owner == 1 && !done)) begin
      pend[1] = 1'b1; cap_w[1] = x.d_w; cap_hw[1] = x.d_hw; cap_adr[1] = x.d_adr;
      cap_we = x.d_we; cap_wd = x.d_wdata;
    end
    if (grant >= 0) begin
      pend[grant] = 1'b0; owner = grant; grant_cyc = cyc; last = grant;
      fly_we = (grant == 1) ? cap_we : 1'b0;
    end else if (owner >= 0 && done) begin
      owner = -1;
    end
    cyc++;
  endfunction

  initial begin
    ins_t  x;
    outs_t e;
    bit    dc;
    int    g;
    bit    dn;

    // Directed table, starting with the first cycle after reset.
    add(in_i(32'h100, 1, 0), '0, 0);
    add('0, o_grant(32'h100, 0, 0, 1, 0), 0);
    add('0, '0, 0);
    add(in_mv(32'hDEAD_BEEF), o_iv(32'hDEAD_BEEF, 0), 0);
    add('0, '0, 0);
    add(ins_t'(in_i(32'h200, 0, 1) | in_d(0, 32'h300, 0, 1, 0)), '0, 0);
    add('0, o_grant(32'h300, 0, 0, 1, 0), 0);
    add(ins_t'(in_mv(32'h1111_1111) | in_i(32'h250, 1, 0) | in_d(0, 32'h400, 0, 0, 0)),
        o_dv(32'h1111_1111, 0), 0);
    add('0, o_grant(32'h200, 0, 0, 0, 1), 0);
    add(in_mv(32'h2222_2222), o_iv(32'h2222_2222, 0), 0);
    add('0, o_grant(32'h400, 0, 0, 0, 0), 0);
    add(in_mv(32'h3333_3333), o_dv(32'h3333_3333, 0), 0);
    add(in_d(1, 32'h2000, 32'h55AA, 1, 0), '0, 0);
    add('0, o_grant(32'h2000, 1, 32'h55AA, 1, 0), 0);
    add(in_mv(32'hABCD), o_dv(32'h0, 0), 1);
    add(in_mv(32'h1234), '0, 0);
    add(in_i(32'h500, 1, 0), '0, 0);
    add(in_d(0, 32'h600, 0, 1, 0), o_grant(32'h500, 0, 0, 1, 0), 0);
    add('0, '0, 0);
    add(in_mv(32'h44), o_iv(32'h44, 0), 0);
    add('0, o_grant(32'h600, 0, 0, 1, 0), 0);
    add(in_mv(32'h55), o_dv(32'h55, 0), 0);
    add('0, '0, 0);
    add(in_i(32'h700, 0, 0), '0, 0);
    add('0, o_grant(32'h700, 0, 0, 0, 0), 0);
    add('0, '0, 0);
    add('0, '0, 0);
    add('0, '0, 0);
    add('0, o_iv(32'h0000_0013, 1), 0);
    add(in_mv(32'h66), '0, 0);
    add(in_d(0, 32'h800, 0, 0, 1), '0, 0);
    add('0, o_grant(32'h800, 0, 0, 0, 1), 0);
    add('0, '0, 0);
    add('0, '0, 0);
    add('0, '0, 0);
    add(in_mv(32'h99), o_dv(32'h99, 0), 0);
    add('0, '0, 0);

    apply(ins_t'(in_mv(32'hFFFF_FFFF) | in_i(32'h10, 1, 1) | in_d(1, 32'h20, 32'h30, 1, 1)));
    #2;
    check("reset_hold", '0, 0);
    @(posedge clk);
    #1;
    check("reset_hold2", '0, 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    for (int i = 0; i < vecs.size(); i++)
      run_cycle(vecs[i].in, vecs[i].exp, vecs[i].dc, $sformatf("vec%0d", i));

    // Reset while a fetch is outstanding, then a late bus response.
    run_cycle(in_i(32'hA00, 1, 0), '0, 0, "rw_req");
    run_cycle('0, o_grant(32'hA00, 0, 0, 1, 0), 0, "rw_grant");
    run_cycle('0, '0, 0, "rw_wait");
    rst_n = 1'b0;
    apply(ins_t'(in_mv(32'hBAD) | in_i(32'hC00, 1, 0) | in_d(1, 32'hC04, 32'h1, 1, 0)));
    #2;
    check("rw_in_reset", '0, 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    run_cycle('0, '0, 0, "rw_post0");
    run_cycle(in_mv(32'hBAD0), '0, 0, "rw_late_mvalid");
    run_cycle(in_i(32'hB00, 1, 0), '0, 0, "rw_new_req");
    run_cycle('0, o_grant(32'hB00, 0, 0, 1, 0), 0, "rw_new_grant");
    run_cycle(in_mv(32'h77), o_iv(32'h77, 0), 0, "rw_new_resp");

    // Random traffic against the reference model.
    do_reset();
    model_reset();
    for (int n = 0; n < 3000; n++) begin
      x = '0;
      x.i_req   = 1'($urandom_range(0, 3) == 0);
      x.i_w     = 1'($urandom_range(0, 1));
      x.i_hw    = 1'($urandom_range(0, 1));
      x.i_adr   = $urandom;
      x.d_req   = 1'($urandom_range(0, 3) == 0);
      x.d_we    = 1'($urandom_range(0, 1));
      x.d_w     = 1'($urandom_range(0, 1));
      x.d_hw    = 1'($urandom_range(0, 1));
      x.d_adr   = $urandom;
      x.d_wdata = $urandom;
      x.m_valid = 1'($urandom_range(0, 9) < 3);
      x.m_rdata = $urandom;
      model_eval(x, e, dc, g, dn);
      run_cycle(x, e, dc, "random");
      model_update(x, g, dn);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/bus_arbiter.md
BUS_ARBITER -- requirements
Module: bus_arbiter

Interface
REQ-001 The module SHALL have parameter TMO_CYC, default 8'd255, the number of cycles allowed for a bus response before timeout.
REQ-002 The module SHALL have these ports, listed as name, direction, width, meaning:
- clk  in  1  sole clock, rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- i_read_req  in  1  instruction fetch request, one-cycle pulse.
- i_read_w  in  1  fetch word size.
- i_read_hw  in  1  fetch half-word size.
- i_read_adr  in  32  fetch address.
- i_read_valid  out  1  fetch response pulse.
- i_read_data  out  32  fetch read data.
- d_req  in  1  data request, one-cycle pulse.
- d_we  in  1  1 = write, 0 = read.
- d_w  in  1  data word size.
- d_hw  in  1  data half-word size.
- d_adr  in  32  data address.
- d_wdata  in  32  data write data.
- d_valid  out  1  data response pulse.
- d_rdata  out  32  data read data.
- m_req  out  1  shared-bus request pulse.
- m_we  out  1  shared-bus write enable.
- m_w  out  1  shared-bus word size.
- m_hw  out  1  shared-bus half-word size.
- m_adr  out  32  shared-bus address.
- m_wdata  out  32  shared-bus write data.
- m_valid  in  1  shared-bus completion pulse.
- m_rdata  in  32  shared-bus read data.
- bus_err  out  1  timeout pulse.

Function
REQ-003 An i_read_req pulse SHALL set the i_pend flag and capture i_read_w, i_read_hw and i_read_adr; a d_req pulse SHALL set d_pend and capture d_we, d_w, d_hw, d_adr and d_wdata.
REQ-004 A request pulse SHALL be ignored, with no capture, while that port is pending or in flight, except in the cycle its in-flight response completes.
REQ-005 The state machine SHALL have three states: IDLE, I_WAIT and D_WAIT.
REQ-006 In IDLE with any pend flag set, m_req SHALL be 1 for exactly that cycle, with the m_* outputs driven from the granted port's captured fields.
REQ-007 On the clock edge after m_req, the state SHALL move to I_WAIT or D_WAIT, and the granted port's pend flag SHALL clear.
REQ-008 Grant SHALL use round-robin order: with one port pending, that port is granted; with both pending, the port not granted last is granted. The last-grant bit SHALL reset to inst, so data wins the first tie.
REQ-009 Latency: a request pulse in cycle t SHALL give m_req in cycle t+1 when the arbiter is idle.
REQ-010 m_valid SHALL be ignored in IDLE.
REQ-011 In I_WAIT, m_valid SHALL drive i_read_valid=1 and i_read_data=m_rdata in the same cycle (combinational), and the state SHALL return to IDLE.
REQ-012 D_WAIT SHALL behave as REQ-011 using d_valid and d_rdata. For writes, d_valid acknowledges the write and d_rdata is don't-care.
REQ-013 A re-grant SHALL occur no earlier than the cycle after m_valid, giving at most one outstanding bus transaction.
REQ-014 When m_req is 0, m_adr, m_wdata, m_we, m_w and m_hw SHALL be 0.
REQ-015 An 8-bit timeout counter SHALL clear on entry to I_WAIT or D_WAIT and increment each WAIT cycle without m_valid.
REQ-016 When the timeout counter reaches TMO_CYC, the owner SHALL receive a valid pulse with data 32'h00000013, bus_err SHALL pulse for 1 cycle, and the state SHALL return to IDLE.
REQ-017 m_valid arriving in the same cycle as the timeout SHALL take precedence: real data is returned and bus_err stays 0.
REQ-018 A request for the non-owner port during WAIT SHALL be captured and served after completion.
REQ-019 A request for the owner port in its completion cycle SHALL be captured, and that port is granted in the next IDLE cycle subject to REQ-008.

Reset
REQ-020 Reset SHALL force state IDLE, both pend flags 0, last-grant = inst, timeout counter 0, and all captured fields 0.
REQ-021 During and immediately after reset, outputs SHALL be m_req=0, all m_* outputs=0, i_read_valid=0, d_valid=0, i_read_data=0, d_rdata=0 and bus_err=0.
REQ-022 Reset during WAIT SHALL discard the transaction; a late m_valid after reset SHALL produce no valid pulse.

Verification
REQ-023 Fetch only: i_read_req in cycle 0 with adr 0x100 -> m_req=1 with m_adr=0x100 in cycle 1; m_valid with m_rdata=0xDEADBEEF in cycle 3 -> i_read_valid=1 and i_read_data=0xDEADBEEF in cycle 3.
REQ-024 Tie: i_read_req and d_req together after reset -> data granted first, inst granted in the cycle after data's m_valid; repeating the tie -> inst granted first.
REQ-025 Data write: d_we=1, d_adr=0x2000, d_wdata=0x55AA -> m_we=1, m_wdata=0x55AA; m_valid -> d_valid pulse; i_read_valid stays 0.
REQ-026 Timeout with TMO_CYC=4 and no m_valid -> i_read_valid and bus_err pulse 4 cycles after grant, i_read_data=0x00000013, state IDLE.
REQ-027 Reset asserted in I_WAIT, m_valid pulsed 2 cycles after release -> no i_read_valid; a new i_read_req is served normally.
